// File: rtl/usbf_dma_sched_if.sv
// usbf_dma_sched_if: request/engine/ack bundle between the register file, the DMA scheduler and the shared DMA engine.
interface usbf_dma_sched_if;
    logic [15:0] dma_req_i;
    logic [15:0] ch_en_i;
    logic [15:0] hi_pri_i;
    logic [15:0] dma_ack_o;
    logic        eng_req_o;
    logic [3:0]  eng_ch_o;
    logic        eng_gnt_i;
    logic        eng_word_i;
    logic        eng_abort_i;
    logic        busy_o;
    modport slave (
        input  dma_req_i, ch_en_i, hi_pri_i, eng_gnt_i, eng_word_i, eng_abort_i,
        output dma_ack_o, eng_req_o, eng_ch_o, busy_o
    );
    modport master (
        output dma_req_i, ch_en_i, hi_pri_i, eng_gnt_i, eng_word_i, eng_abort_i,
        input  dma_ack_o, eng_req_o, eng_ch_o, busy_o
    );
endinterface

// File: rtl/usbf_dma_sched.sv
// usbf_dma_sched: two-class round-robin scheduler granting one DMA channel at a time to the shared engine for a bounded burst.
module usbf_dma_sched #(
    parameter int BURST_MAX = 8
) (
    input  logic clk_i,
    input  logic rst,
    usbf_dma_sched_if.slave bus
);
    typedef enum logic [2:0] {IDLE, ARB, REQ, XFER, DONE} state_t;
    state_t      state_q, state_d;
    logic [3:0]  rr_ptr_q, rr_ptr_d;
    logic [3:0]  cur_ch_q, cur_ch_d;
    logic [8:0]  wcnt_q, wcnt_d;
    logic [15:0] ack_q, ack_d;
    logic        eng_req_q, eng_req_d;
    logic        busy_q, busy_d;
    logic [15:0] elig, hi;
    logic [3:0]  win;
    logic        cur_ok, last_word;
    // first set bit of v at or above p, wrapping 15 -> 0
    function automatic logic [3:0] first_from(input logic [15:0] v, input logic [3:0] p);
        logic [3:0] r;
        r = p;
        for (int i = 15; i >= 0; i--)
            if (v[p + 4'(i)]) r = p + 4'(i);
        return r;
    endfunction
    always_comb begin
        elig      = bus.dma_req_i & bus.ch_en_i;
        hi        = elig & bus.hi_pri_i;
        win       = first_from((hi != '0) ? hi : elig, rr_ptr_q);
        cur_ok    = bus.dma_req_i[cur_ch_q] & bus.ch_en_i[cur_ch_q];
        last_word = bus.eng_word_i && (wcnt_q == 9'(BURST_MAX - 1));
        state_d   = state_q;
        rr_ptr_d  = rr_ptr_q;
        cur_ch_d  = cur_ch_q;
        wcnt_d    = wcnt_q;
        ack_d     = '0;
        case (state_q)
            IDLE: state_d = (elig != '0) ? ARB : IDLE;
            ARB: begin
                cur_ch_d = (elig != '0) ? win : cur_ch_q;
                state_d  = (elig != '0) ? REQ : IDLE;
            end
            REQ: begin
                wcnt_d  = bus.eng_gnt_i ? 9'd0 : wcnt_q;
                state_d = bus.eng_gnt_i ? XFER : (cur_ok ? REQ : IDLE);
            end
            XFER: begin
                ack_d   = bus.eng_word_i ? (16'h1 << cur_ch_q) : '0;
                wcnt_d  = bus.eng_word_i ? wcnt_q + 9'd1 : wcnt_q;
                state_d = (last_word || bus.eng_abort_i || !cur_ok) ? DONE : XFER;
            end
            DONE: begin
                rr_ptr_d = cur_ch_q + 4'd1;
                state_d  = IDLE;
            end
            default: state_d = IDLE;
        endcase
        eng_req_d = (state_d == REQ) || (state_d == XFER);
        busy_d    = state_d != IDLE;
    end
    always_ff @(posedge clk_i or negedge rst) begin
        if (!rst) begin
            state_q   <= IDLE;
            rr_ptr_q  <= '0;
            cur_ch_q  <= '0;
            wcnt_q    <= '0;
            ack_q     <= '0;
            eng_req_q <= 1'b0;
            busy_q    <= 1'b0;
        end else begin
            state_q   <= state_d;
            rr_ptr_q  <= rr_ptr_d;
            cur_ch_q  <= cur_ch_d;
            wcnt_q    <= wcnt_d;
            ack_q     <= ack_d;
            eng_req_q <= eng_req_d;
            busy_q    <= busy_d;
        end
    end
    assign bus.dma_ack_o = ack_q;
    assign bus.eng_req_o = eng_req_q;
    assign bus.eng_ch_o  = cur_ch_q;
    assign bus.busy_o    = busy_q;
endmodule

// File: tb/tb_usbf_dma_sched.sv
// tb_usbf_dma_sched: randomized burst traffic against a transaction-level scheduler model with a queue-based monitor.
module tb_usbf_dma_sched;
    localparam int BM = 8;
    logic clk_i = 1'b0;
    logic rst   = 1'b1;
    usbf_dma_sched_if bus();
    usbf_dma_sched #(.BURST_MAX(BM)) dut (.clk_i(clk_i), .rst(rst), .bus(bus));
    always #5 clk_i = ~clk_i;
    int   vectors = 0;
    int   errors  = 0;
    int   exp_ch[$];
    int   exp_acks[$];
    int   rr   = 0;
    int   cur  = 0;
    int   acks = 0;
    logic prev = 1'b0;
    task automatic check(input string name, input int act, input int req);
        vectors++;
        if (act != req) begin
            errors++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, req);
        end
    endtask
    task automatic report(input string name, input string what);
        vectors++;
        errors++;
        $display("FAIL %s: got %s, expected nothing outstanding", name, what);
    endtask
    // pick the winner straight from the class and rotation rules
    function automatic int model_pick(input logic [15:0] req, input logic [15:0] en,
                                      input logic [15:0] hp, input int ptr);
        logic [15:0] e, h, s;
        e = req & en;
        h = e & hp;
        s = (h != 0) ? h : e;
        for (int k = 0; k < 16; k++)
            if (s[(ptr + k) % 16]) return (ptr + k) % 16;
        return -1;
    endfunction
    always @(negedge clk_i) begin
        if (!rst) begin
            acks = 0;
            prev = 1'b0;
        end else begin
            if (bus.dma_ack_o != 0) begin
                acks++;
                check("ack_onehot", int'(bus.dma_ack_o), 1 << cur);
            end
            if (bus.eng_req_o && !prev) begin
                if (exp_ch.size() == 0) report("unexpected_req", "a new request");
                else cur = exp_ch.pop_front();
            end
            if (bus.eng_req_o) begin
                check("eng_ch", int'(bus.eng_ch_o), cur);
                check("busy", int'(bus.busy_o), 1);
            end
            if (!bus.eng_req_o && prev) begin
                if (exp_acks.size() == 0) report("unexpected_end", "a burst end");
                else check("ack_count", acks, exp_acks.pop_front());
                acks = 0;
            end
            prev = bus.eng_req_o;
        end
    end
    task automatic tick();
        @(posedge clk_i);
        #1;
    endtask
    task automatic rand_side();
        bus.eng_word_i  = 1'($urandom);
        bus.eng_abort_i = 1'($urandom);
    endtask
    task automatic wait_req(output logic got);
        got = 1'b0;
        for (int i = 0; i < 20 && !got; i++) begin
            tick();
            rand_side();
            got = bus.eng_req_o;
        end
        if (!got) check("req_timeout", 0, 1);
    endtask
    // plan: 0 full burst, 1 abort with word n, 2 drop request after n words, 3 withdraw in REQ, 4 bare abort
    task automatic run_txn(input logic [15:0] req, input logic [15:0] en, input logic [15:0] hp,
                           input int plan, input int n);
        int   w, cnt;
        logic got;
        w   = model_pick(req, en, hp, rr);
        cnt = (plan == 0) ? BM : n;
        exp_ch.push_back(w);
        exp_acks.push_back((plan == 3 || plan == 4) ? 0 : cnt);
        bus.dma_req_i = req;
        bus.ch_en_i   = en;
        bus.hi_pri_i  = hp;
        wait_req(got);
        if (!got) return;
        if (plan == 3) begin
            repeat ($urandom % 3) begin
                tick();
                rand_side();
            end
            if ($urandom % 2) bus.ch_en_i = '0;
            else bus.dma_req_i = '0;
            tick();
            rand_side();
            return;
        end
        repeat ($urandom % 3) begin
            tick();
            rand_side();
        end
        bus.eng_gnt_i = 1'b1;
        tick();
        bus.eng_gnt_i   = 1'b0;
        bus.eng_word_i  = 1'b0;
        bus.eng_abort_i = 1'b0;
        if (plan == 4) begin
            bus.eng_abort_i = 1'b1;
            tick();
        end else begin
            for (int k = 1; k <= cnt; k++) begin
                if ($urandom % 3 == 0) begin
                    bus.eng_word_i  = 1'b0;
                    bus.eng_abort_i = 1'b0;
                    tick();
                end
                bus.eng_word_i  = 1'b1;
                bus.eng_abort_i = (plan == 1 && k == cnt);
                tick();
            end
            bus.eng_word_i  = 1'b0;
            bus.eng_abort_i = 1'b0;
            if (plan == 2) begin
                bus.dma_req_i[w] = 1'b0;
                tick();
            end
        end
        rand_side();
        rr = (w + 1) % 16;
    endtask
    task automatic rand_txn();
        logic [15:0] req, en, hp;
        int b, plan, n;
        req  = 16'($urandom);
        en   = 16'($urandom | $urandom);
        hp   = 16'($urandom & $urandom & $urandom);
        b    = $urandom % 16;
        if ((req & en) == 0) begin
            req[b] = 1'b1;
            en[b]  = 1'b1;
        end
        plan = $urandom % 5;
        n    = (plan == 1) ? 1 + $urandom % BM : (plan == 2) ? 1 + $urandom % (BM - 1) : 0;
        run_txn(req, en, hp, plan, n);
    endtask
    initial begin
        logic got;
        bus.dma_req_i   = '0;
        bus.ch_en_i     = '0;
        bus.hi_pri_i    = '0;
        bus.eng_gnt_i   = 1'b0;
        bus.eng_word_i  = 1'b0;
        bus.eng_abort_i = 1'b0;
        #2 rst = 1'b0;
        #10;
        check("reset_ack", int'(bus.dma_ack_o), 0);
        check("reset_eng_req", int'(bus.eng_req_o), 0);
        check("reset_eng_ch", int'(bus.eng_ch_o), 0);
        check("reset_busy", int'(bus.busy_o), 0);
        @(posedge clk_i);
        #3 rst = 1'b1;
        tick();
        tick();
        run_txn(16'h0004, 16'hFFFF, 16'h0000, 0, 0);
        repeat (5) run_txn(16'h8011, 16'hFFFF, 16'h0000, 0, 0);
        run_txn(16'h0303, 16'hFFFF, 16'h0200, 0, 0);
        repeat (3) run_txn(16'h0103, 16'hFFFF, 16'h0200, 0, 0);
        run_txn(16'h0303, 16'hFFFF, 16'h0200, 0, 0);
        run_txn(16'h0004, 16'hFFFF, 16'h0000, 2, 3);
        run_txn(16'h0004, 16'hFFFF, 16'h0000, 1, 5);
        run_txn(16'h0020, 16'hFFFF, 16'h0000, 3, 0);
        run_txn(16'h00C0, 16'hFF7F, 16'h0080, 0, 0);
        repeat (200) rand_txn();
        run_txn(16'h0020, 16'hFFFF, 16'h0000, 0, 0);
        exp_ch.push_back(model_pick(16'h0400, 16'hFFFF, 16'h0000, rr));
        bus.dma_req_i = 16'h0400;
        bus.ch_en_i   = 16'hFFFF;
        bus.hi_pri_i  = 16'h0000;
        wait_req(got);
        bus.eng_word_i  = 1'b0;
        bus.eng_abort_i = 1'b0;
        bus.eng_gnt_i   = 1'b1;
        tick();
        bus.eng_gnt_i  = 1'b0;
        bus.eng_word_i = 1'b1;
        tick();
        tick();
        bus.eng_word_i = 1'b0;
        #2 rst = 1'b0;
        #1;
        check("rst_mid_ack", int'(bus.dma_ack_o), 0);
        check("rst_mid_eng_req", int'(bus.eng_req_o), 0);
        check("rst_mid_busy", int'(bus.busy_o), 0);
        check("rst_mid_eng_ch", int'(bus.eng_ch_o), 0);
        bus.dma_req_i = '0;
        rr = 0;
        @(posedge clk_i);
        #3 rst = 1'b1;
        tick();
        tick();
        check("busy_after_reset", int'(bus.busy_o), 0);
        run_txn(16'h0401, 16'hFFFF, 16'h0000, 0, 0);
        bus.dma_req_i   = '0;
        bus.eng_word_i  = 1'b0;
        bus.eng_abort_i = 1'b0;
        repeat (6) tick();
        check("pending_requests", exp_ch.size(), 0);
        check("pending_bursts", exp_acks.size(), 0);
        check("idle_busy", int'(bus.busy_o), 0);
        $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
        $finish;
    end
endmodule
